// File: rtl/adder_fc_pkg.sv
// Shared definitions for the multi-operand flow-controlled adder.
//   ACC_W_DEFAULT : default width of the accumulate-length field
//   state_t       : join/accumulate FSM state (IDLE, ACCUM)
//   calc_out_w()  : result width that cannot wrap for N_CH operands summed
//                   over up to 2^ACC_W-1 tuples
package adder_fc_pkg;

  localparam int ACC_W_DEFAULT = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  function automatic int calc_out_w(input int width, input int n_ch, input int acc_w);
    return width + $clog2(n_ch) + acc_w;
  endfunction

endpackage

// File: rtl/flow_control_fifo.sv
// Single-channel valid/ready FIFO used to buffer one adder input channel.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   up_vld/up_rdy   : producer handshake; up_rdy depends only on registered
//                     occupancy (and is low while in reset)
//   up_data         : producer payload
//   dn_vld/dn_rdy   : consumer handshake; dn_vld = FIFO non-empty
//   dn_data         : head entry
module flow_control_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_vld,
  input  logic             dn_rdy,
  output logic [WIDTH-1:0] dn_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // A full FIFO refuses a write even when it is popped in the same cycle,
  // keeping up_rdy free of any path from the downstream side.
  assign up_rdy  = rst & ~full;
  assign dn_vld  = ~empty;
  assign dn_data = mem[rd_ptr[AW-1:0]];

  assign push = up_vld & up_rdy;
  assign pop  = dn_rdy & ~empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= up_data;
  end

endmodule

// File: rtl/multi_operand_adder_with_flow_control.sv
// N-channel flow-controlled adder. Each channel is buffered in its own FIFO;
// when every FIFO holds a token and the output register can take a value,
// one token is popped from every channel and the heads are summed. In single
// mode each tuple sum is emitted; in accumulate mode acc_len tuples (0 -> 1)
// are summed into one result.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   in_vld/in_rdy     : per-channel producer handshake
//   in_data           : packed operands, channel i at [i*WIDTH +: WIDTH]
//   acc_en, acc_len   : mode and group length, sampled at group start
//   sum_vld/sum_rdy   : consumer handshake
//   sum_data          : zero-extended unsigned result
module multi_operand_adder_with_flow_control
  import adder_fc_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N_CH  = 4,
  parameter  int DEPTH = 2,
  parameter  int ACC_W = ACC_W_DEFAULT,
  localparam int OUT_W = calc_out_w(WIDTH, N_CH, ACC_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_vld,
  output logic [N_CH-1:0]       in_rdy,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic                  acc_en,
  input  logic [ACC_W-1:0]      acc_len,
  output logic                  sum_vld,
  input  logic                  sum_rdy,
  output logic [OUT_W-1:0]      sum_data
);

  localparam logic [ACC_W-1:0] ACC_ONE = 1;

  logic [WIDTH-1:0] head [N_CH];
  logic [N_CH-1:0]  head_vld;
  logic             fire;

  logic [OUT_W-1:0] tuple_sum_p0;
  logic [ACC_W-1:0] len_start;
  logic [ACC_W-1:0] count_inc;
  logic             load_p0;
  logic [OUT_W-1:0] load_val_p0;

  state_t           state;
  logic [ACC_W-1:0] len_q;
  logic [ACC_W-1:0] count;
  logic [OUT_W-1:0] acc;

  logic             vld_p1;
  logic [OUT_W-1:0] sum_p1;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    flow_control_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .up_vld  (in_vld[i]),
      .up_rdy  (in_rdy[i]),
      .up_data (in_data[i*WIDTH +: WIDTH]),
      .dn_vld  (head_vld[i]),
      .dn_rdy  (fire),
      .dn_data (head[i])
    );
  end

  // ---- stage p0: join FIFO heads, sum, decide whether a result is produced
  // All FIFOs pop together or not at all. The output-register condition is
  // required even in ACCUM, where no result is loaded on most fires.
  assign fire = (&head_vld) & (~vld_p1 | sum_rdy);

  always_comb begin
    tuple_sum_p0 = '0;
    for (int i = 0; i < N_CH; i++) begin
      tuple_sum_p0 = tuple_sum_p0 + OUT_W'(head[i]);
    end
  end

  assign len_start = (acc_len == '0) ? ACC_ONE : acc_len;
  assign count_inc = count + ACC_ONE;

  always_comb begin
    load_p0     = 1'b0;
    load_val_p0 = tuple_sum_p0;
    if (fire) begin
      if (state == IDLE) begin
        load_p0 = ~acc_en | (len_start == ACC_ONE);
      end else if (count_inc == len_q) begin
        load_p0     = 1'b1;
        load_val_p0 = acc + tuple_sum_p0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      len_q <= ACC_ONE;
      count <= '0;
      acc   <= '0;
    end else if (fire) begin
      if (state == IDLE) begin
        // Mode and length are captured only here; later changes wait for IDLE.
        len_q <= len_start;
        if (!load_p0) begin
          acc   <= tuple_sum_p0;
          count <= ACC_ONE;
          state <= ACCUM;
        end
      end else if (load_p0) begin
        acc   <= '0;
        count <= '0;
        state <= IDLE;
      end else begin
        acc   <= acc + tuple_sum_p0;
        count <= count_inc;
      end
    end
  end

  // ---- stage p1: single-entry output register, load and drain in one cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      sum_p1 <= '0;
    end else if (load_p0) begin
      vld_p1 <= 1'b1;
      sum_p1 <= load_val_p0;
    end else if (sum_rdy) begin
      vld_p1 <= 1'b0;
    end
  end

  assign sum_vld  = vld_p1;
  assign sum_data = sum_p1;

endmodule

// File: tb/tb_multi_operand_adder_with_flow_control.sv
// Self-checking bench for multi_operand_adder_with_flow_control (N_CH=4,
// WIDTH=8, DEPTH=2, ACC_W=4). Results are collected by a monitor and compared
// in order against table constants, hand-computed sums and a tuple/group model.
module tb_multi_operand_adder_with_flow_control;

  localparam int WIDTH = 8;
  localparam int N_CH  = 4;
  localparam int DEPTH = 2;
  localparam int ACC_W = 4;
  localparam int OUT_W = WIDTH + $clog2(N_CH) + ACC_W;

  logic                  clk;
  logic                  rst;
  logic [N_CH-1:0]       in_vld;
  logic [N_CH-1:0]       in_rdy;
  logic [N_CH*WIDTH-1:0] in_data;
  logic                  acc_en;
  logic [ACC_W-1:0]      acc_len;
  logic                  sum_vld;
  logic                  sum_rdy;
  logic [OUT_W-1:0]      sum_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  longint got[$];
  int     got_cyc[$];

  typedef struct {
    logic [N_CH*WIDTH-1:0] data;
    longint                exp;
  } vec_t;
  vec_t tbl[6];

  multi_operand_adder_with_flow_control #(
    .WIDTH (WIDTH),
    .N_CH  (N_CH),
    .DEPTH (DEPTH),
    .ACC_W (ACC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .acc_en   (acc_en),
    .acc_len  (acc_len),
    .sum_vld  (sum_vld),
    .sum_rdy  (sum_rdy),
    .sum_data (sum_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // A result is taken when valid and ready are both high ahead of the edge.
  always @(negedge clk) begin
    if (rst && sum_vld && sum_rdy) begin
      got.push_back(longint'(sum_data));
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_mask(input logic [N_CH*WIDTH-1:0] d, input logic [N_CH-1:0] mask,
                           output int t_acc);
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] a;
    int n;
    pending = mask;
    n = 0;
    in_data = d;
    while (pending != '0 && n < 50) begin
      in_vld = pending;
      a = pending & in_rdy;
      step();
      pending = pending & ~a;
      n++;
    end
    in_vld = '0;
    t_acc = cyc;
    if (pending != '0) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: pending %b required 0", pending);
    end
  endtask

  task automatic push_all(input logic [N_CH*WIDTH-1:0] d);
    int t;
    push_mask(d, '1, t);
  endtask

  task automatic wait_results(input int n, input int bound, input string name);
    int k;
    k = 0;
    while (got.size() < n && k < bound) begin
      step();
      k++;
    end
    if (got.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d results expected %0d", name, got.size(), n);
    end
  endtask

  task automatic clear_results();
    got.delete();
    got_cyc.delete();
  endtask

  // Model: tuples are formed in arrival order across channels; groups of L
  // consecutive tuples sum into one result (L=1 in single mode).
  task automatic run_random(input bit en, input int len_in, input int T);
    int vals[N_CH][64];
    int idx[N_CH];
    longint expv[$];
    logic [N_CH-1:0] v;
    logic [N_CH-1:0] a;
    int L, G, c;
    bit all_sent;
    L = (en && len_in > 1) ? len_in : 1;
    G = T / L;
    acc_en  = en;
    acc_len = ACC_W'(len_in);
    for (int ch = 0; ch < N_CH; ch++) begin
      idx[ch] = 0;
      for (int j = 0; j < T; j++) vals[ch][j] = int'($urandom_range(0, 255));
    end
    for (int g = 0; g < G; g++) begin
      longint s;
      s = 0;
      for (int j = g * L; j < (g + 1) * L; j++)
        for (int ch = 0; ch < N_CH; ch++) s += vals[ch][j];
      expv.push_back(s);
    end
    clear_results();
    c = 0;
    while (c < 4000) begin
      all_sent = 1'b1;
      for (int ch = 0; ch < N_CH; ch++) if (idx[ch] < T) all_sent = 1'b0;
      if (all_sent && got.size() >= G) break;
      for (int ch = 0; ch < N_CH; ch++) begin
        v[ch] = (idx[ch] < T) && ($urandom_range(0, 3) != 0);
        in_data[ch*WIDTH +: WIDTH] = WIDTH'(vals[ch][(idx[ch] < T) ? idx[ch] : 0]);
      end
      in_vld  = v;
      sum_rdy = ($urandom_range(0, 3) != 0);
      a = in_vld & in_rdy;
      step();
      for (int ch = 0; ch < N_CH; ch++) if (a[ch]) idx[ch]++;
      c++;
    end
    in_vld  = '0;
    sum_rdy = 1'b1;
    repeat (5) step();
    check("rnd_count", got.size(), G);
    for (int g = 0; g < G && g < got.size(); g++) check("rnd_sum", got[g], expv[g]);
    acc_en  = 1'b0;
    acc_len = '0;
  endtask

  initial begin
    int t;
    int k[N_CH];
    logic [N_CH-1:0] a;

    tbl[0] = '{{8'd4,   8'd3,   8'd2,   8'd1},   10};
    tbl[1] = '{{8'd255, 8'd255, 8'd255, 8'd255}, 1020};
    tbl[2] = '{{8'd0,   8'd0,   8'd0,   8'd0},   0};
    tbl[3] = '{{8'hFE,  8'h01,  8'h7F,  8'h80},  510};
    tbl[4] = '{{8'd40,  8'd30,  8'd20,  8'd10},  100};
    tbl[5] = '{{8'd0,   8'd255, 8'd0,   8'd255}, 510};

    rst = 1'b0; in_vld = '0; in_data = '0; acc_en = 1'b0; acc_len = '0; sum_rdy = 1'b1;
    repeat (2) step();
    check("reset_sum_vld", sum_vld, 0);
    check("reset_sum_data", sum_data, 0);
    check("reset_in_rdy", in_rdy, 0);
    rst = 1'b1;
    step();
    check("post_reset_in_rdy", in_rdy, 4'hF);

    // Single mode table: value and two-cycle latency
    for (int i = 0; i < 6; i++) begin
      clear_results();
      push_mask(tbl[i].data, '1, t);
      wait_results(1, 10, "tbl");
      if (got.size() >= 1) begin
        check("tbl_sum", got[0], tbl[i].exp);
        check("tbl_latency", got_cyc[0], t + 1);
      end
    end

    // Skew: channel 3 arrives five cycles late
    clear_results();
    push_mask({8'd0, 8'd30, 8'd20, 8'd10}, 4'b0111, t);
    repeat (5) step();
    check("skew_no_early", got.size(), 0);
    check("skew_sum_vld", sum_vld, 0);
    push_mask({8'd40, 24'd0}, 4'b1000, t);
    wait_results(1, 10, "skew");
    if (got.size() >= 1) check("skew_sum", got[0], 100);
    repeat (5) step();
    check("skew_single", got.size(), 1);

    // Backpressure: DEPTH in FIFO plus one in the output register
    clear_results();
    sum_rdy = 1'b0;
    for (int ch = 0; ch < N_CH; ch++) k[ch] = 0;
    repeat (10) begin
      for (int ch = 0; ch < N_CH; ch++) in_data[ch*WIDTH +: WIDTH] = WIDTH'(10 * k[ch] + ch + 1);
      in_vld = '1;
      a = in_vld & in_rdy;
      step();
      for (int ch = 0; ch < N_CH; ch++) if (a[ch]) k[ch]++;
    end
    in_vld = '0;
    for (int ch = 0; ch < N_CH; ch++) check("bp_accepted", k[ch], DEPTH + 1);
    check("bp_in_rdy", in_rdy, 0);
    check("bp_sum_vld", sum_vld, 1);
    sum_rdy = 1'b1;
    wait_results(3, 20, "bp");
    for (int j = 0; j < 3 && j < got.size(); j++) begin
      longint s;
      s = 0;
      for (int ch = 0; ch < N_CH; ch++) s += 10 * j + ch + 1;
      check("bp_order", got[j], s);
    end
    repeat (5) step();
    check("bp_count", got.size(), 3);

    // Accumulate three tuples of ones
    clear_results();
    acc_en = 1'b1; acc_len = 4'd3;
    repeat (3) push_all({4{8'd1}});
    wait_results(1, 20, "acc3");
    if (got.size() >= 1) check("acc3_sum", got[0], 12);
    repeat (5) step();
    check("acc3_count", got.size(), 1);

    // acc_len of zero behaves as one
    clear_results();
    acc_len = 4'd0;
    push_all({4{8'd2}});
    wait_results(1, 10, "len0");
    if (got.size() >= 1) check("len0_sum", got[0], 8);
    repeat (5) step();
    check("len0_count", got.size(), 1);

    // acc_len changed mid-group is ignored, then applies to the next group
    clear_results();
    acc_len = 4'd2;
    push_all({8'd4, 8'd3, 8'd2, 8'd1});
    repeat (2) step();
    acc_len = 4'd4;
    push_all({4{8'd1}});
    wait_results(1, 10, "mid");
    if (got.size() >= 1) check("mid_sum", got[0], 14);
    repeat (4) push_all({4{8'd1}});
    wait_results(2, 20, "mid_next");
    if (got.size() >= 2) check("mid_next_sum", got[1], 16);

    // Maximum: fifteen tuples of all-ones operands
    clear_results();
    acc_len = 4'd15;
    repeat (15) push_all({4{8'd255}});
    wait_results(1, 20, "max");
    if (got.size() >= 1) check("max_sum", got[0], 15300);

    // Reset in ACCUM with two FIFOs holding a token
    clear_results();
    acc_len = 4'd4;
    repeat (2) push_all({4{8'd1}});
    push_mask({16'd0, 8'd1, 8'd1}, 4'b0011, t);
    step();
    rst = 1'b0;
    step();
    check("rst_mid_sum_vld", sum_vld, 0);
    check("rst_mid_in_rdy", in_rdy, 0);
    check("rst_mid_sum_data", sum_data, 0);
    step();
    rst = 1'b1;
    step();
    check("rst_mid_in_rdy_after", in_rdy, 4'hF);
    check("rst_mid_no_result", got.size(), 0);
    acc_en = 1'b0;
    push_all({8'd8, 8'd7, 8'd6, 8'd5});
    wait_results(1, 10, "rst_fresh");
    if (got.size() >= 1) check("rst_fresh_sum", got[0], 26);
    repeat (3) step();

    // Randomized traffic against the tuple/group model
    run_random(1'b0, 0, 40);
    run_random(1'b1, 3, 36);
    run_random(1'b1, 0, 20);
    run_random(1'b1, 5, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_operand_adder_with_flow_control.md
Name: multi_operand_adder_with_flow_control

Overview:
- N-channel successor of the two-operand flow-controlled adder.
- Each input channel is buffered in a parametrised-depth FIFO. The block joins one token from every channel and sums them.
- Either emits each sum (single mode) or accumulates a programmable number of joined tuples into one total (accumulate mode).
- Sits between independent valid/ready producers and one valid/ready consumer in the arithmetic datapath.

Parameters:
- WIDTH, 8, bits per input operand.
- N_CH, 4, number of input channels (2..16).
- DEPTH, 2, entries per input FIFO (power of 2, >=2).
- ACC_W, 4, width of the accumulate-length field.
- OUT_W (localparam), WIDTH+$clog2(N_CH)+ACC_W, output width; overflow-free by construction.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-low reset; asserted when 0, sampled on clk rising edge.
- in_vld  input  N_CH  per-channel valid.
- in_rdy  output  N_CH  per-channel ready.
- in_data  input  N_CH*WIDTH  packed operands; channel i occupies bits [i*WIDTH +: WIDTH].
- acc_en  input  1  0 = single mode, 1 = accumulate mode.
- acc_len  input  ACC_W  tuples per accumulated result; 0 is treated as 1.
- sum_vld  output  1  result valid.
- sum_rdy  input  1  consumer ready.
- sum_data  output  OUT_W  result, zero-extended unsigned.

Behaviour:
- Reset (rst==0 at edge):
  - all FIFOs empty; accumulator=0; count=0; state=IDLE; output register empty.
  - sum_vld=0, sum_data=0.
  - in_rdy=0 while rst is low.
- Reset mid-operation: discards all buffered tokens and partial accumulations. No result is emitted for them.
- Input channel i:
  - transfer on in_vld[i]&in_rdy[i].
  - in_rdy[i] = !full[i], driven from registered state only; no combinational path from in_vld or sum_rdy.
  - A FIFO that is full at start of cycle does not accept, even if popped that cycle.
  - Channels are independent; any skew between channels is absorbed up to DEPTH tokens.
- Join (fire):
  - fire = all FIFOs non-empty & out_can_accept.
  - out_can_accept = !out_full | sum_rdy.
  - On fire, every FIFO pops exactly one entry. Never pop a subset.
  - tuple_sum = unsigned sum of all heads, computed at OUT_W bits.
- FSM:
  - IDLE (count==0): on fire, latch mode_q=acc_en and len_q=max(acc_len,1).
    - If mode_q==0 or len_q==1: load output register with tuple_sum; stay IDLE.
    - Else: acc=tuple_sum, count=1, go to ACCUM.
  - ACCUM: on fire:
    - If count+1==len_q: load output register with acc+tuple_sum; acc=0; count=0; go to IDLE.
    - Else: acc+=tuple_sum; count++.
  - acc_en/acc_len are sampled only at group start; changes during ACCUM are ignored until return to IDLE.
  - In ACCUM, out_can_accept is still required on every fire, which keeps the logic simple.
- Output register:
  - single entry; sum_vld=out_full; sum_data holds value stable until sum_vld&sum_rdy.
  - Load and drain may occur in the same cycle, giving full throughput.
- Latency/throughput:
  - Single mode, all FIFOs empty: token accepted at edge t gives sum_vld high after edge t+1 (2-cycle latency).
  - Sustained throughput 1 tuple/cycle when sum_rdy=1.
- Boundaries:
  - Backpressure: sum_rdy=0 with output full stalls fire. FIFOs fill, then in_rdy drops per channel.
  - Max values: all-ones operands with len 2^ACC_W-1 fit OUT_W without wrap.

Decomposition:
- Package adder_fc_pkg: function for OUT_W computation; FSM state enum (IDLE, ACCUM); ACC_W default constant.
- One sub-module: flow_control_fifo (WIDTH, DEPTH; up/down valid/ready; registered full/empty), instantiated N_CH times via generate.
- Join, FSM and output register live in the top.

Test Plan:
- Single mode, N_CH=4, WIDTH=8: inputs 1,2,3,4 simultaneously, sum_rdy=1 -> sum_data=10 exactly 2 cycles after acceptance; then 255 x4 -> 1020.
- Skew: ch0..2 valid at cycle 0, ch3 at cycle 5 -> no fire until ch3 lands; single result; no FIFO pops early.
- Backpressure: sum_rdy=0 for 10 cycles with all channels streaming -> each in_rdy drops after DEPTH+1 accepted tokens (DEPTH in FIFO, 1 in output register); release gives in-order results, none lost or duplicated.
- Accumulate: acc_en=1, acc_len=3, tuples (1,1,1,1)x3 -> one result 12 after third fire. acc_len=0 -> behaves as 1. Change acc_len mid-group -> ignored.
- Max: acc_len=15, all operands 255 -> sum_data=15300, no truncation.
- Reset during ACCUM with FIFOs half full -> sum_vld=0, in_rdy=0 during reset, all FIFOs empty after; next tuple produces a fresh result.
